// File: rtl/cpu_mem_sequencer_if.sv
// Command and byte-memory bus between the 6502 control unit, the memory
// sequencer and CPU memory. slave = sequencer view, master = surrounding logic.
interface cpu_mem_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_pagewrap;

    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_rdy;

    logic [15:0] mdr;
    logic        done;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_pagewrap,
        output cmd_ready,
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_rdy,
        output mdr, done, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_pagewrap,
        input  cmd_ready,
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_rdy,
        input  mdr, done, busy
    );
endinterface

// File: rtl/cpu_mem_sequencer.sv
// Byte-wide memory access sequencer: runs 1- or 2-byte read/write commands
// against CPU memory and assembles the little-endian 16-bit MDR.
module cpu_mem_sequencer #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    cpu_mem_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] OP_KEEP   = 3'b000;
    localparam logic [2:0] OP_READ1  = 3'b001;
    localparam logic [2:0] OP_READ2  = 3'b010;
    localparam logic [2:0] OP_WRITE1 = 3'b011;
    localparam logic [2:0] OP_WRITE2 = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO_REQ,
        S_LO_WAIT,
        S_HI_REQ,
        S_HI_WAIT
    } state_e;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              pagewrap;
    } cmd_t;

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]        op_in_c;
    logic [ADDR_W-1:0] addr2_c;

    function automatic logic is_read(input logic [2:0] op);
        return (op == OP_READ1) || (op == OP_READ2);
    endfunction

    // Second byte address; pagewrap reproduces the indirect-JMP carry bug.
    assign addr2_c = cmd_q.pagewrap
                   ? {cmd_q.addr[15:8], cmd_q.addr[7:0] + 8'd1}
                   : cmd_q.addr + 16'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            mdr_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            mdr_q       <= mdr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        mdr_d       = mdr_q;
        done_d      = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        op_in_c     = (bus.cmd_op > OP_WRITE2) ? OP_KEEP : bus.cmd_op;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d = '{op:       op_in_c,
                              addr:     bus.cmd_addr,
                              wdata:    bus.cmd_wdata,
                              pagewrap: bus.cmd_pagewrap};
                    if (op_in_c != OP_KEEP) begin
                        state_d    = S_LO_REQ;
                        mem_addr_d = bus.cmd_addr;
                        if (is_read(op_in_c)) begin
                            mem_rd_d = 1'b1;
                        end else begin
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = bus.cmd_wdata[7:0];
                        end
                    end
                end
            end

            S_LO_REQ: begin
                if (!bus.mem_rdy) begin
                    mem_rd_d = is_read(cmd_q.op);
                    mem_wr_d = !is_read(cmd_q.op);
                end else if (is_read(cmd_q.op)) begin
                    state_d = S_LO_WAIT;
                    cnt_d   = CNT_W'(RD_LATENCY);
                end else if (cmd_q.op == OP_WRITE2) begin
                    state_d     = S_HI_REQ;
                    mem_addr_d  = addr2_c;
                    mem_wr_d    = 1'b1;
                    mem_wdata_d = cmd_q.wdata[15:8];
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            S_LO_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    mdr_d[7:0] = bus.mem_rdata;
                    if (cmd_q.op == OP_READ2) begin
                        state_d    = S_HI_REQ;
                        mem_addr_d = addr2_c;
                        mem_rd_d   = 1'b1;
                    end else begin
                        mdr_d[15:8] = 8'h00;
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                    end
                end
            end

            S_HI_REQ: begin
                if (!bus.mem_rdy) begin
                    mem_rd_d = is_read(cmd_q.op);
                    mem_wr_d = !is_read(cmd_q.op);
                end else if (is_read(cmd_q.op)) begin
                    state_d = S_HI_WAIT;
                    cnt_d   = CNT_W'(RD_LATENCY);
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            S_HI_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    mdr_d[15:8] = bus.mem_rdata;
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mdr       = mdr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
